uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` byte transmitter between `NUM_REQ` requesters. Each requester presents a byte with a level request; the arbiter picks one, drives the transmitter's start/data inputs, tracks the transfer through `i_tx_busy`/`i_tx_done`, and acknowledges the requester. It sits between protocol front-ends (debug console, status reporter, etc.) and the single serial TX pin.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `ID_W`, default `$clog2(NUM_REQ)`: width of the grant index; derived, do not override.
- `BUSY_TIMEOUT`, default 4: cycles to wait for `i_tx_busy` after start before aborting.
- `clk`  in  1  single clock for the block.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_req`  in  NUM_REQ  level request per requester; held until the matching `o_ack`.
- `i_req_data`  in  NUM_REQ*8  byte per requester; requester k uses bits [8k+7:8k]; stable while `i_req[k]`=1.
- `o_ack`  out  NUM_REQ  one-hot, one-cycle pulse when requester's byte is latched.
- `o_grant_valid`  out  1  high from START through WAIT_DONE.
- `o_grant_id`  out  ID_W  index of current or last granted requester.
- `o_tx_start`  out  1  to transmitter start input; one-cycle pulse.
- `o_tx_data`  out  8  to transmitter data input; registered, held from START until the next START.
- `i_tx_busy`  in  1  transmitter busy flag.
- `i_tx_done`  in  1  transmitter done flag (high while transmitter idle).
- `o_err`  out  1  one-cycle pulse on busy timeout.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE: if `|i_req` and `i_tx_busy`=0 and `i_tx_done`=1 -> pick winner, latch its byte into `o_tx_data`, set `o_grant_id`, go START. Otherwise stay.
- START (1 cycle): `o_tx_start`=1, `o_grant_valid`=1, `o_ack[grant]`=1; advance round-robin pointer to grant+1 mod NUM_REQ; go WAIT_BUSY.
- WAIT_BUSY: on `i_tx_busy`=1 go WAIT_DONE. Counter reaches `BUSY_TIMEOUT` without busy -> `o_err` pulse, go IDLE (byte is considered lost; ack already given).
- WAIT_DONE: on `i_tx_busy`=0 and `i_tx_done`=1 go IDLE.
- Round-robin: search starts at pointer, wraps from NUM_REQ-1 to 0; lowest index at or after pointer wins.
- Requests dropped before grant are ignored; a request dropping after ack has no effect on the in-flight byte.
- Requester may change `i_req_data` or re-request in the cycle after `o_ack`.

## Timing
- Reset values: state IDLE, pointer 0, `o_ack`=0, `o_grant_valid`=0, `o_grant_id`=0, `o_tx_start`=0, `o_tx_data`=8'h00, `o_err`=0.
- Request-to-start latency: 1 cycle (request seen in IDLE at edge n, START in cycle n+1).
- Back-to-back: at least one IDLE cycle between WAIT_DONE exit and next START.
- Per-byte overhead beyond the 10 bit periods: 3 cycles minimum.
- Reset asserted mid-transfer: block returns to IDLE immediately; the IDLE busy/done check prevents a new start until the transmitter finishes the in-flight frame.
- Simultaneous requests: only one ack per start; losers keep waiting and are served in rotation order.

## Configuration
- `UART_TX_ARB_FIXED_PRI_EN` defined: fixed priority, lowest index always wins; pointer logic removed, pointer reads as 0.
- Undefined (default): round-robin as above.

## Structure
- Shared package `uart_pkg`: state enumeration (IDLE/START/WAIT_BUSY/WAIT_DONE) and the `BUSY_TIMEOUT` default constant.
- One sub-module: `uart_rr_pick`, a combinational round-robin picker (inputs `req`, `ptr`; outputs `gnt_onehot`, `gnt_id`, `any`). Reused unchanged in fixed-priority mode with `ptr`=0.

## Test plan
- Single requester: `i_req`=4'b0010, data[15:8]=8'hA5 -> `o_ack`=4'b0010 for 1 cycle, `o_tx_start` pulse, `o_tx_data`=8'hA5, serial line shows A5 with start/stop bits.
- All four requesting, data 8'h10/8'h11/8'h12/8'h13 held -> bytes transmitted in order 10,11,12,13, then 10 again; exactly one ack per byte.
- Pointer wrap: grant requester 3, then `i_req`=4'b1001 -> next grant is 0, not 3.
- Transmitter model never raises busy -> `o_err` pulses exactly 4 cycles after WAIT_BUSY entry, state returns to IDLE, no hang.
- `i_rst_n` low during WAIT_DONE with busy still high -> outputs at reset values; no `o_tx_start` until busy=0 and done=1.
- With `UART_TX_ARB_FIXED_PRI_EN`, `i_req`=4'b0101 held -> requester 0 granted every time; requester 2 only after requester 0 drops.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART TX arbiter and its picker.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int BUSY_TIMEOUT_DEF = 4;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: lowest requesting index at or after ptr
// wins, wrapping from N-1 back to 0.
module uart_rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt_onehot,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  logic found;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    found      = 1'b0;
    // First pass covers [ptr, N-1]; second pass wraps to [0, ptr-1].
    for (int k = 0; k < N; k++) begin
      if (!found && req[k] && (k >= int'(ptr))) begin
        found         = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_id        = ID_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!found && req[k]) begin
        found         = 1'b1;
        gnt_onehot[k] = 1'b1;
        gnt_id        = ID_W'(k);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between NUM_REQ requesters.
// Define UART_TX_ARB_FIXED_PRI_EN for fixed lowest-index-wins priority.
//
// Handshake: i_req[k] is a level held with stable i_req_data until o_ack[k]
// pulses for one cycle; the byte is latched then, and the requester may drop
// or re-request from the following cycle.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = $clog2(NUM_REQ),
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [NUM_REQ*8-1:0] i_req_data,
  output logic [NUM_REQ-1:0]   o_ack,
  output logic                 o_grant_valid,
  output logic [ID_W-1:0]      o_grant_id,
  output logic                 o_tx_start,
  output logic [7:0]           o_tx_data,
  input  logic                 i_tx_busy,
  input  logic                 i_tx_done,
  output logic                 o_err,
  output state_t               o_state
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 grant_valid_q, grant_valid_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 tx_start_q, tx_start_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 err_q, err_d;

  logic [NUM_REQ-1:0]   pick_onehot;
  logic [ID_W-1:0]      pick_id;
  logic                 pick_any;
  logic [7:0]           pick_data;
  logic                 tx_ready;

  uart_rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_pick (
    .req        (i_req),
    .ptr        (ptr_q),
    .gnt_onehot (pick_onehot),
    .gnt_id     (pick_id),
    .any        (pick_any)
  );

  always_comb begin
    pick_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_onehot[k]) pick_data = i_req_data[k*8 +: 8];
    end
  end

  // Also gates restart after a reset that landed mid-frame.
  assign tx_ready = !i_tx_busy && i_tx_done;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    ack_d         = '0;
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    err_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any && tx_ready) begin
          state_d       = START;
          grant_id_d    = pick_id;
          tx_data_d     = pick_data;
          ack_d         = pick_onehot;
          tx_start_d    = 1'b1;
          grant_valid_d = 1'b1;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
`ifdef UART_TX_ARB_FIXED_PRI_EN
        ptr_d   = '0;
`else
        ptr_d   = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
`endif
      end
      WAIT_BUSY: begin
        if (i_tx_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
          // Byte is dropped: the requester was already acked.
          state_d       = IDLE;
          err_d         = 1'b1;
          grant_valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (tx_ready) begin
          state_d       = IDLE;
          grant_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      ack_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      ack_q         <= ack_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      err_q         <= err_d;
    end
  end

  assign o_ack         = ack_q;
  assign o_grant_valid = grant_valid_q;
  assign o_grant_id    = grant_id_q;
  assign o_tx_start    = tx_start_q;
  assign o_tx_data     = tx_data_q;
  assign o_err         = err_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table, timeout, reset mid-frame,
// held-request rotation, plus a 1-cycle-per-bit transmitter and serial receiver.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam logic [31:0] D = 32'h1312_1110;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  ack;
  logic        grant_valid;
  logic [1:0]  grant_id;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        tx_done = 1'b1;
  logic        err;
  state_t      state;

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  int start_cnt = 0;
  int ack_cnt = 0;

  bit         model_en = 1'b1;
  bit         tx_active = 1'b0;
  int         phase = 0;
  logic [7:0] tx_shift = '0;
  logic       tx_line = 1'b1;
  int         rx_cnt = 0;
  logic [7:0] rx_byte = '0;

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .BUSY_TIMEOUT (4)
  ) dut (
    .clk           (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_req_data    (req_data),
    .o_ack         (ack),
    .o_grant_valid (grant_valid),
    .o_grant_id    (grant_id),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .i_tx_busy     (tx_busy),
    .i_tx_done     (tx_done),
    .o_err         (err),
    .o_state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter: latches the byte on start, one bit per cycle, not reset by the arbiter.
  always @(negedge clk) begin
    if (tx_start) start_cnt++;
    ack_cnt += $countones(ack);
    if (!tx_active) begin
      if (model_en && tx_start) begin
        tx_active = 1'b1;
        tx_busy   = 1'b1;
        tx_done   = 1'b0;
        phase     = 0;
        tx_shift  = tx_data;
        tx_line   = 1'b0;
      end
    end else begin
      phase++;
      if (phase <= 8) begin
        tx_line  = tx_shift[0];
        tx_shift = tx_shift >> 1;
      end else if (phase == 9) begin
        tx_line = 1'b1;
      end else begin
        tx_active = 1'b0;
        tx_busy   = 1'b0;
        tx_done   = 1'b1;
      end
    end
  end

  // Serial receiver and scoreboard.
  always @(posedge clk) begin
    if (rx_cnt == 0) begin
      if (tx_line == 1'b0) rx_cnt = 1;
    end else if (rx_cnt <= 8) begin
      rx_byte = {tx_line, rx_byte[7:1]};
      rx_cnt++;
    end else begin
      check("rx_stop_bit", 32'(tx_line), 32'd1);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rx_unexpected_byte: got 0x%0h, expected no byte", rx_byte);
      end else begin
        check("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
      end
      rx_cnt = 0;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input int max_cyc, output int cyc);
    cyc = 0;
    while (cyc < max_cyc) begin
      tick();
      cyc++;
      if (tx_start) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL start_timeout: got no o_tx_start in %0d cycles, expected one", max_cyc);
    cyc = -1;
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      if (state == IDLE && !tx_busy && tx_done) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL idle_timeout: got state %0d after %0d cycles, expected IDLE", state, max_cyc);
  endtask

  task automatic check_grant(input string tag, input logic [1:0] exp_id,
                             input logic [7:0] exp_data, input bit push);
    logic [3:0] exp_ack;
    exp_ack = 4'b0001 << exp_id;
    check({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    check({tag, "_grant_id"}, 32'(grant_id), 32'(exp_id));
    check({tag, "_tx_data"}, 32'(tx_data), 32'(exp_data));
    check({tag, "_grant_valid"}, 32'(grant_valid), 32'd1);
    check({tag, "_state"}, 32'(state), 32'(START));
    if (push) exp_q.push_back(exp_data);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_grant_valid"}, 32'(grant_valid), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_state"}, 32'(state), 32'(IDLE));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [1:0]  exp_id;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int cyc;
    bit prev_busy;
    logic [1:0] hold_id;

`ifdef UART_TX_ARB_FIXED_PRI_EN
    vecs[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
    vecs[1] = '{4'b1111, D, 2'd0, 8'h10};
    vecs[2] = '{4'b0001, D, 2'd0, 8'h10};
    vecs[3] = '{4'b0101, D, 2'd0, 8'h10};
    vecs[4] = '{4'b1000, D, 2'd3, 8'h13};
    vecs[5] = '{4'b1001, D, 2'd0, 8'h10};
    vecs[6] = '{4'b1110, D, 2'd1, 8'h11};
    vecs[7] = '{4'b1011, D, 2'd0, 8'h10};
    vecs[8] = '{4'b0110, D, 2'd1, 8'h11};
`else
    vecs[0] = '{4'b0010, 32'h0000_A500, 2'd1, 8'hA5};
    vecs[1] = '{4'b1111, D, 2'd2, 8'h12};
    vecs[2] = '{4'b0001, D, 2'd0, 8'h10};
    vecs[3] = '{4'b0101, D, 2'd2, 8'h12};
    vecs[4] = '{4'b1000, D, 2'd3, 8'h13};
    vecs[5] = '{4'b1001, D, 2'd0, 8'h10};
    vecs[6] = '{4'b1110, D, 2'd1, 8'h11};
    vecs[7] = '{4'b1011, D, 2'd3, 8'h13};
    vecs[8] = '{4'b0110, D, 2'd1, 8'h11};
`endif

    tick();
    tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      req_data = vecs[i].data;
      req      = vecs[i].req;
      wait_start(5, cyc);
      check($sformatf("vec%0d_latency", i), 32'(cyc), 32'd1);
      check_grant($sformatf("vec%0d", i), vecs[i].exp_id, vecs[i].exp_data, 1'b1);
      tick();
      req = '0;
      wait_idle(40);
    end

    // Transmitter never answers: o_err four cycles after WAIT_BUSY entry.
    model_en = 1'b0;
    req_data = D;
    req      = 4'b0100;
    wait_start(5, cyc);
    check_grant("timeout", 2'd2, 8'h12, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) req = '0;
      check($sformatf("timeout_err_early%0d", i), 32'(err), 32'd0);
      check($sformatf("timeout_state%0d", i), 32'(state), 32'(WAIT_BUSY));
    end
    tick();
    check("timeout_err_pulse", 32'(err), 32'd1);
    check("timeout_state_idle", 32'(state), 32'(IDLE));
    check("timeout_grant_valid", 32'(grant_valid), 32'd0);
    tick();
    check("timeout_err_clear", 32'(err), 32'd0);
    model_en = 1'b1;

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // All four held: rotation from pointer 0 with a fixed 12-cycle spacing.
    req_data = D;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_start(30, cyc);
`ifdef UART_TX_ARB_FIXED_PRI_EN
      hold_id = 2'd0;
`else
      hold_id = 2'(i % 4);
`endif
      if (i > 0) check($sformatf("hold%0d_gap", i), 32'(cyc), 32'd12);
      check_grant($sformatf("hold%0d", i), hold_id, 8'h10 + 8'(hold_id), 1'b1);
    end
    tick();
    req = '0;
    wait_idle(40);

    // Reset during WAIT_DONE with the transmitter still busy.
    req = 4'b0001;
    wait_start(5, cyc);
    check_grant("rst_first", 2'd0, 8'h10, 1'b1);
    for (int i = 0; i < 10 && state != WAIT_DONE; i++) tick();
    check("rst_reached_wait_done", 32'(state), 32'(WAIT_DONE));
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    tick();
    rst_n = 1'b1;
    prev_busy = tx_busy;
    cyc = 0;
    while (cyc < 30) begin
      prev_busy = tx_busy;
      tick();
      cyc++;
      if (tx_start) break;
    end
    check("rst_restart_seen", 32'(tx_start), 32'd1);
    check("rst_restart_after_tx_idle", 32'(prev_busy), 32'd0);
    check_grant("rst_restart", 2'd0, 8'h10, 1'b1);
    tick();
    req = '0;
    wait_idle(40);

    repeat (20) tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("start_count", 32'(start_cnt), 32'd17);
    check("ack_count", 32'(ack_cnt), 32'd17);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
